// File: rtl/prefetch_queue_pkg.sv
// prefetch_queue_pkg
//   Shared definitions for the instruction prefetch queue and its neighbours
//   (fetch/decode reuse the request FSM encoding and window constants).
package prefetch_queue_pkg;

  localparam int PQ_ADDR_W      = 32;  // CPU address width
  localparam int PQ_WIN_W       = 32;  // instruction window / memory word width
  localparam int PQ_WORD_BYTES  = 4;   // bytes per memory word
  localparam int PQ_MAX_CONSUME = 4;   // most bytes decode may retire per cycle

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } req_state_t;

endpackage

// File: rtl/prefetch_queue_if.sv
// prefetch_queue_if
//   Bundles the memory read port, the redirect port, the decode consume port
//   and the instruction window of the prefetch queue.
//   master : the prefetch queue (drives mem_req/mem_addr and the window)
//   slave  : the environment (memory + decode), drives acks, flush, consume
interface prefetch_queue_if import prefetch_queue_pkg::*; #(
  parameter int ADDR_W = PQ_ADDR_W
);

  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [PQ_WIN_W-1:0] mem_rdata;
  logic                flush;
  logic [ADDR_W-1:0]   flush_addr;
  logic                consume;
  logic [3:0]          consume_len;
  logic [PQ_WIN_W-1:0] ope;
  logic                ope_valid;
  logic [ADDR_W-1:0]   eip;

  modport master (
    output mem_req, mem_addr, ope, ope_valid, eip,
    input  mem_ack, mem_rdata, flush, flush_addr, consume, consume_len
  );

  modport slave (
    input  mem_req, mem_addr, ope, ope_valid, eip,
    output mem_ack, mem_rdata, flush, flush_addr, consume, consume_len
  );

endinterface

// File: rtl/prefetch_queue_byte_ring.sv
// prefetch_queue_byte_ring
//   Circular byte store. Write port takes 0..4 bytes (oldest in [31:24]) at
//   wr_ptr; read port presents the 4 bytes starting at rd_ptr, wrapping.
//   Ports: clk, wr_len (0..4), wr_ptr, wr_data, rd_ptr, rd_win.
//   Holds data only; pointers and occupancy live in the parent.
module prefetch_queue_byte_ring import prefetch_queue_pkg::*; #(
  parameter int DEPTH_BYTES = 16,
  parameter int PTR_W       = $clog2(DEPTH_BYTES)
) (
  input  logic                clk,
  input  logic [2:0]          wr_len,
  input  logic [PTR_W-1:0]    wr_ptr,
  input  logic [PQ_WIN_W-1:0] wr_data,
  input  logic [PTR_W-1:0]    rd_ptr,
  output logic [PQ_WIN_W-1:0] rd_win
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    for (int i = 0; i < PQ_WORD_BYTES; i++) begin
      if (3'(i) < wr_len) begin
        mem[wr_ptr + PTR_W'(i)] <= wr_data[31-8*i -: 8];
      end
    end
  end

  always_comb begin
    rd_win = '0;
    for (int i = 0; i < PQ_WORD_BYTES; i++) begin
      rd_win[31-8*i -: 8] = mem[rd_ptr + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue
//   Instruction prefetch queue: fetches aligned words from memory, buffers
//   them as a byte stream and presents a byte-aligned 32-bit window (ope) at
//   address eip. Decode retires 1..4 bytes per cycle; flush redirects fetch
//   to any byte address.
//   Ports: clk, reset (sync, active-high), bus (prefetch_queue_if.master):
//     mem_req/mem_addr/mem_ack/mem_rdata - single-outstanding word reads
//     flush/flush_addr                   - redirect
//     consume/consume_len                - bytes retired by decode
//     ope/ope_valid/eip                  - instruction window
module prefetch_queue import prefetch_queue_pkg::*; #(
  parameter int DEPTH_BYTES = 16,
  parameter int ADDR_W      = PQ_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  prefetch_queue_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] REFILL_MAX = CNT_W'(DEPTH_BYTES - PQ_WORD_BYTES);

  req_state_t          state, state_nxt;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [ADDR_W-1:0]   fetch_addr, fetch_nxt;
  logic [ADDR_W-1:0]   req_addr;
  logic [ADDR_W-1:0]   eip_r;
  logic [1:0]          skip;
  logic                drop, drop_nxt;
  logic                ack, wr_accept, load_req, win_valid;
  logic [2:0]          wr_len, cons_len;
  logic [PQ_WIN_W-1:0] wr_data, window, ope_w;

  function automatic logic [2:0] sat_len(input logic [3:0] len);
    return (len > 4'(PQ_MAX_CONSUME)) ? 3'(PQ_MAX_CONSUME) : len[2:0];
  endfunction

  prefetch_queue_byte_ring #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .PTR_W       (PTR_W)
  ) u_ring (
    .clk     (clk),
    .wr_len  (wr_len),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr),
    .rd_win  (window)
  );

  always_comb begin
    // Acks are only meaningful while a request is outstanding.
    ack       = bus.mem_ack && (state == ST_REQ);
    win_valid = (count >= CNT_W'(PQ_WORD_BYTES));
    cons_len  = (bus.consume && win_valid) ? sat_len(bus.consume_len) : 3'd0;
    wr_accept = ack && !bus.flush && !drop;
    wr_len    = wr_accept ? (3'd4 - {1'b0, skip}) : 3'd0;
    // Left-align the surviving bytes so the ring always writes from [31:24].
    wr_data   = bus.mem_rdata << {skip, 3'b000};

    count_nxt = '0;
    fetch_nxt = fetch_addr;
    drop_nxt  = drop;
    state_nxt = state;
    if (bus.flush) begin
      fetch_nxt = {bus.flush_addr[ADDR_W-1:2], 2'b00};
    end else begin
      count_nxt = count + CNT_W'(wr_len) - CNT_W'(cons_len);
      if (wr_accept) fetch_nxt = fetch_addr + ADDR_W'(PQ_WORD_BYTES);
    end

    if (ack)                               drop_nxt = 1'b0;
    else if (bus.flush && state == ST_REQ) drop_nxt = 1'b1;

    // An ack may immediately reissue, giving back-to-back words.
    case (state)
      ST_IDLE: if (count_nxt <= REFILL_MAX) state_nxt = ST_REQ;
      ST_REQ: begin
        if (ack) begin
          if (bus.flush)                    state_nxt = ST_IDLE;
          else if (count_nxt <= REFILL_MAX) state_nxt = ST_REQ;
          else                              state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    load_req = (state_nxt == ST_REQ) && ((state == ST_IDLE) || ack);

    // Bytes beyond the current occupancy read as zero.
    ope_w = '0;
    for (int i = 0; i < PQ_WORD_BYTES; i++) begin
      if (count > CNT_W'(i)) ope_w[31-8*i -: 8] = window[31-8*i -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= '0;
      req_addr   <= '0;
      eip_r      <= '0;
      skip       <= '0;
      drop       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      fetch_addr <= fetch_nxt;
      drop       <= drop_nxt;
      if (load_req) req_addr <= fetch_nxt;
      if (bus.flush) begin
        rd_ptr <= wr_ptr;
        eip_r  <= bus.flush_addr;
        skip   <= bus.flush_addr[1:0];
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(cons_len);
        wr_ptr <= wr_ptr + PTR_W'(wr_len);
        eip_r  <= eip_r + ADDR_W'(cons_len);
        if (wr_accept) skip <= 2'b00;
      end
    end
  end

  assign bus.mem_req   = (state == ST_REQ);
  assign bus.mem_addr  = req_addr;
  assign bus.ope       = ope_w;
  assign bus.ope_valid = win_valid;
  assign bus.eip       = eip_r;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue
//   Randomized bench for prefetch_queue with a byte-stream reference model:
//   the queue is modelled as a FIFO of bytes taken from memory in address
//   order starting at the last redirect address.
module tb_prefetch_queue;
  import prefetch_queue_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prefetch_queue_if #(.ADDR_W(32)) bus();

  prefetch_queue #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acks = 0;
  int          idle_run = 0;
  logic [7:0]  q_m[$];
  logic [31:0] eip_m, nba_m;
  bit          stale_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hB802_0000;
    if (a == 32'h4) return 32'h89E5_C3F4;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    case (a[1:0])
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  task automatic check_outputs();
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) if (i < q_m.size()) e[31-8*i -: 8] = q_m[i];
    chk("ope", bus.ope, e);
    chk("ope_valid", 32'(bus.ope_valid), 32'(q_m.size() >= 4));
    chk("eip", bus.eip, eip_m);
    if (q_m.size() == DEPTH) chk("full_no_req", 32'(bus.mem_req), 32'd0);
    idle_run = (!bus.mem_req && q_m.size() <= DEPTH - 4) ? idle_run + 1 : 0;
    chk("req_live", 32'(idle_run > 2), 32'd0);
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic cycle(input bit cons, input logic [3:0] clen, input bit fl,
                       input logic [31:0] fa, input int ack_pct);
    bit ack;
    int n;
    ack = bus.mem_req && (int'($urandom_range(99)) < ack_pct);
    bus.mem_ack     = ack;
    bus.mem_rdata   = ack ? mem_word(bus.mem_addr) : $urandom;
    bus.consume     = cons;
    bus.consume_len = clen;
    bus.flush       = fl;
    bus.flush_addr  = fa;
    if (ack) n_acks++;
    if (fl) begin
      q_m.delete();
      eip_m   = fa;
      nba_m   = fa;
      stale_m = bus.mem_req && !ack;
    end else begin
      n = 0;
      if (cons && q_m.size() >= 4) n = (clen > 4'd4) ? 4 : int'(clen);
      repeat (n) void'(q_m.pop_front());
      eip_m += 32'(n);
      if (ack) begin
        if (stale_m) stale_m = 1'b0;
        else begin
          chk("req_addr", bus.mem_addr, {nba_m[31:2], 2'b00});
          do begin
            q_m.push_back(mem_byte(nba_m));
            nba_m += 32'd1;
          end while (nba_m[1:0] != 2'b00);
          chk("no_overflow", 32'(q_m.size() <= DEPTH), 32'd1);
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input bit stale_ack);
    reset           = 1'b1;
    bus.mem_ack     = stale_ack;
    bus.mem_rdata   = $urandom;
    bus.flush       = 1'b0;
    bus.flush_addr  = '0;
    bus.consume     = 1'b0;
    bus.consume_len = '0;
    @(posedge clk);
    #1;
    q_m.delete();
    eip_m    = '0;
    nba_m    = '0;
    stale_m  = 1'b0;
    idle_run = 0;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_ope", bus.ope, 32'd0);
    chk("rst_ope_valid", 32'(bus.ope_valid), 32'd0);
    chk("rst_eip", bus.eip, 32'd0);
    reset       = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] fa;
    bit          fl;

    do_reset(1'b0);

    // First fetch, then two words and consumes of 1 and 4.
    cycle(0, 0, 0, 0, 0);
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_addr", bus.mem_addr, 32'h0);
    cycle(0, 0, 0, 0, 100);
    chk("word0_ope", bus.ope, 32'hB802_0000);
    chk("word0_valid", 32'(bus.ope_valid), 32'd1);
    cycle(0, 0, 0, 0, 100);
    cycle(1, 4'd1, 0, 0, 0);
    chk("cons1_ope", bus.ope, 32'h0200_0089);
    chk("cons1_eip", bus.eip, 32'h1);
    cycle(1, 4'd4, 0, 0, 100);
    w = mem_word(32'h8);
    chk("cons4_ope", bus.ope, {24'hE5C3F4, w[31:24]});
    chk("cons4_eip", bus.eip, 32'h5);

    // Fill to capacity with instant acks and no consume.
    do_reset(1'b0);
    cycle(0, 0, 0, 0, 0);
    n_acks = 0;
    repeat (8) cycle(0, 0, 0, 0, 100);
    chk("full_acks", 32'(n_acks), 32'd4);
    chk("full_req", 32'(bus.mem_req), 32'd0);
    chk("full_ope", bus.ope, 32'hB802_0000);
    cycle(1, 4'd4, 0, 0, 0);
    chk("refill_req", 32'(bus.mem_req), 32'd1);
    chk("refill_addr", bus.mem_addr, 32'h10);

    // Flush while the request to 0x8 is outstanding.
    do_reset(1'b0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 100);
    cycle(0, 0, 0, 0, 100);
    chk("pend_addr", bus.mem_addr, 32'h8);
    cycle(0, 0, 1, 32'h1003, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 100);
    chk("redir_addr0", bus.mem_addr, 32'h1000);
    chk("redir_valid0", 32'(bus.ope_valid), 32'd0);
    cycle(0, 0, 0, 0, 100);
    chk("redir_addr1", bus.mem_addr, 32'h1004);
    chk("redir_valid1", 32'(bus.ope_valid), 32'd0);
    cycle(0, 0, 0, 0, 100);
    w = {mem_byte(32'h1003), 24'h0};
    chk("redir_byte", {bus.ope[31:24], 24'h0}, w);
    chk("redir_eip", bus.eip, 32'h1003);
    chk("redir_valid2", 32'(bus.ope_valid), 32'd1);

    // Continuous consume 3 with acks every cycle: pointers wrap many times.
    repeat (60) cycle(1, 4'd3, 0, 0, 100);

    // Reset during a pending request with a stale ack in the reset cycle.
    do_reset(1'b1);
    cycle(0, 0, 0, 0, 0);
    chk("rr_addr", bus.mem_addr, 32'h0);
    cycle(0, 0, 0, 0, 100);
    chk("rr_ope", bus.ope, 32'hB802_0000);
    chk("rr_eip", bus.eip, 32'h0);

    // Flush, consume and ack together: flush wins.
    cycle(0, 0, 0, 0, 100);
    cycle(1, 4'd4, 1, 32'h20, 100);
    chk("fw_valid", 32'(bus.ope_valid), 32'd0);
    chk("fw_ope", bus.ope, 32'd0);
    chk("fw_eip", bus.eip, 32'h20);
    cycle(0, 0, 0, 0, 0);
    chk("fw_addr", bus.mem_addr, 32'h20);

    // Random traffic, including redirects near the top of the address space.
    for (int k = 0; k < 400; k++) begin
      fl = ($urandom_range(99) < 3);
      fa = ($urandom_range(3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(7))) : $urandom;
      cycle(1'($urandom_range(1)), 4'($urandom_range(15)), fl, fa, 60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
